// File: rtl/ide_multi_port_ctrl.sv
// ide_multi_port_ctrl: multi-channel 68000-to-IDE PIO glue with timed strobes,
// per-channel interrupt pending/enable/force registers and an activity LED stretcher.
module ide_multi_port_ctrl #(
   parameter int         NCH        = 2,
   parameter logic [7:0] BASE       = 8'hDA,
   parameter int         SETUP_CYC  = 1,
   parameter int         STROBE_CYC = 3,
   parameter int         LED_HOLD   = 16
) (
   input  logic             cpuclk7,
   input  logic             n_reset_clocked,
   input  logic             nas,
   input  logic             r_w,
   input  logic [11:0]      AH,
   input  logic [2:0]       AL,
   input  logic [15:0]      d_in,
   output logic [15:0]      d_out,
   output logic             d_oe,
   input  logic [15:0]      dd_in,
   output logic [15:0]      dd_out,
   output logic             dd_oe,
   input  logic [NCH-1:0]   ide_intrq,
   input  logic [NCH-1:0]   ndasp,
   output logic [2*NCH-1:0] cs_n,
   output logic [2:0]       da,
   output logic             nior,
   output logic             niow,
   output logic             dtack,
   output logic             int2,
   output logic             led_n
);
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, REG, ACK} state_t;
   state_t state;
   logic as1, as_s, rw;
   logic [3:0] cnt;
   logic [1:0] sel;
   logic base_hit, tf_hit, reg_hit, wr;
   logic [NCH-1:0] pending, enable, frc, irq1, irq_s, src, src_d, rise, clr, dasp1, dasp_s;
   logic [15:0] rd;
   logic [7:0] led_cnt;
   // AH carries A[23:12], so the window byte is AH[11:4] and A15 is AH[3]
   assign base_hit = AH[11:4] == BASE;
   assign tf_hit   = base_hit && !AH[3] && int'(AH[2:1]) < NCH;
   assign reg_hit  = base_hit && AH[3];
   assign dd_out   = {d_in[7:0], d_in[15:8]};
   assign wr       = state == REG && as_s && !rw;
   assign src      = irq_s | frc;
   assign rise     = src & ~src_d;
   assign clr      = (wr && sel == 2'd0) ? d_in[8+:NCH] : '0;
   assign led_n    = led_cnt == 8'd0;
   always_comb begin
      rd = sel == 2'd0 ? {{(8-NCH){1'b0}}, pending, 8'h00} :
           sel == 2'd1 ? {{(8-NCH){1'b0}}, enable, 8'h00} :
           sel == 2'd2 ? {{(8-NCH){1'b0}}, frc, 8'h00} :
                         {4'(NCH), 4'h2, 8'h00};
   end
   always_ff @(posedge cpuclk7 or negedge n_reset_clocked) begin
      if (!n_reset_clocked) begin
         as1 <= 1'b0;
         as_s <= 1'b0;
         irq1 <= '0;
         irq_s <= '0;
         src_d <= '0;
         dasp1 <= '1;
         dasp_s <= '1;
      end else begin
         as1 <= !nas;
         as_s <= as1;
         irq1 <= ide_intrq;
         irq_s <= irq1;
         src_d <= src;
         dasp1 <= ndasp;
         dasp_s <= dasp1;
      end
   end
   always_ff @(posedge cpuclk7 or negedge n_reset_clocked) begin
      if (!n_reset_clocked) begin
         state <= IDLE;
         cnt <= '0;
         rw <= 1'b1;
         sel <= '0;
         cs_n <= '1;
         da <= 3'b111;
         nior <= 1'b1;
         niow <= 1'b1;
         dtack <= 1'b0;
         d_oe <= 1'b0;
         dd_oe <= 1'b0;
         d_out <= '0;
      end else if (state != IDLE && !as_s) begin
         // covers both the normal end of cycle and an abort
         state <= IDLE;
         cs_n <= '1;
         da <= 3'b111;
         nior <= 1'b1;
         niow <= 1'b1;
         dtack <= 1'b0;
         d_oe <= 1'b0;
         dd_oe <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (as_s && tf_hit) begin
                  state <= SETUP;
                  cs_n <= ~((2*NCH)'(1) << {AH[2:1], AH[0]});
                  da <= AL;
                  rw <= r_w;
                  dd_oe <= !r_w;
                  cnt <= 4'(SETUP_CYC - 1);
               end else if (as_s && reg_hit) begin
                  state <= REG;
                  rw <= r_w;
                  sel <= AH[1:0];
               end
            SETUP:
               if (cnt == 4'd0) begin
                  state <= STROBE;
                  nior <= !rw;
                  niow <= rw;
                  cnt <= 4'(STROBE_CYC - 1);
               end else cnt <= cnt - 4'd1;
            STROBE:
               if (cnt == 4'd0) begin
                  state <= ACK;
                  nior <= 1'b1;
                  niow <= 1'b1;
                  dtack <= 1'b1;
                  d_oe <= rw;
                  if (rw) d_out <= {dd_in[7:0], dd_in[15:8]};
               end else cnt <= cnt - 4'd1;
            REG: begin
               state <= ACK;
               dtack <= 1'b1;
               d_oe <= rw;
               if (rw) d_out <= rd;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge cpuclk7 or negedge n_reset_clocked) begin
      if (!n_reset_clocked) begin
         pending <= '0;
         enable <= '0;
         frc <= '0;
         int2 <= 1'b0;
         led_cnt <= '0;
      end else begin
         pending <= (pending & ~clr) | rise;
         if (wr && sel == 2'd1) enable <= d_in[8+:NCH];
         if (wr && sel == 2'd2) frc <= d_in[8+:NCH];
         int2 <= |(pending & enable);
         led_cnt <= (!(&dasp_s) || state == STROBE) ? 8'(LED_HOLD) : led_cnt - {7'd0, led_cnt != 8'd0};
      end
   end
endmodule

// File: tb/tb_ide_multi_port_ctrl.sv
// tb_ide_multi_port_ctrl: scoreboard bench for ide_multi_port_ctrl at default parameters.
module tb_ide_multi_port_ctrl;
   localparam int SETUP = 1, STROBE = 3, HOLD = 16;
   logic cpuclk7 = 1'b0, n_reset_clocked = 1'b0, nas = 1'b1, r_w = 1'b1;
   logic [11:0] AH = '0;
   logic [2:0] AL = '0;
   logic [15:0] d_in = '0, dd_in = '0, d_out, dd_out;
   logic d_oe, dd_oe, nior, niow, dtack, int2, led_n;
   logic [1:0] ide_intrq = '0, ndasp = '1;
   logic [3:0] cs_n;
   logic [2:0] da;
   int n_cmp = 0, n_bad = 0;
   logic [15:0] exp_q[$];
   bit acked;
   int n_set, n_rd, n_wr, n_oe, n;
   logic [3:0] cs_seen;
   logic [2:0] da_seen;
   logic d_oe_ack, dd_oe_ack, saw_ack;

   ide_multi_port_ctrl dut (
      .cpuclk7(cpuclk7), .n_reset_clocked(n_reset_clocked), .nas(nas), .r_w(r_w),
      .AH(AH), .AL(AL), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
      .dd_in(dd_in), .dd_out(dd_out), .dd_oe(dd_oe), .ide_intrq(ide_intrq), .ndasp(ndasp),
      .cs_n(cs_n), .da(da), .nior(nior), .niow(niow), .dtack(dtack), .int2(int2), .led_n(led_n)
   );

   always #5 cpuclk7 = ~cpuclk7;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic access(input logic [23:0] addr, input logic rw, input logic [15:0] wd,
                         input bit sb, input logic [15:0] exp, input int irq_at);
      @(negedge cpuclk7);
      AH = addr[23:12];
      AL = addr[4:2];
      r_w = rw;
      d_in = wd;
      if (sb) exp_q.push_back(exp);
      nas = 1'b0;
      acked = 0; n_set = 0; n_rd = 0; n_wr = 0; n_oe = 0;
      cs_seen = '1; da_seen = '0; d_oe_ack = 0; dd_oe_ack = 0;
      for (int k = 1; k <= 40 && !acked; k++) begin
         @(negedge cpuclk7);
         if (k == irq_at) ide_intrq[0] = 1'b1;
         if (dtack) begin
            acked = 1;
            d_oe_ack = d_oe;
            dd_oe_ack = dd_oe;
            if (sb && rw) check("rd_data", d_out, exp_q.pop_front());
         end else begin
            if (!nior) n_rd++;
            if (!niow) n_wr++;
            if (nior && niow && !(&cs_n)) n_set++;
            if (dd_oe) n_oe++;
            if (!nior || !niow) begin
               cs_seen = cs_n;
               da_seen = da;
            end
            if (sb && !rw && !niow && n_wr == 1) check("wr_data", dd_out, exp_q.pop_front());
         end
      end
      nas = 1'b1;
      ide_intrq[0] = 1'b0;
      for (int k = 0; k < 10 && (dtack || !(&cs_n)); k++) @(negedge cpuclk7);
   endtask

   task automatic wait_int(input string tag, input logic exp);
      for (int k = 0; k < 8 && int2 !== exp; k++) @(negedge cpuclk7);
      check(tag, int2, exp);
   endtask

   task automatic pulse_irq0();
      @(negedge cpuclk7);
      ide_intrq[0] = 1'b1;
      @(negedge cpuclk7);
      ide_intrq[0] = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge cpuclk7);
      check("rst_cs_n", cs_n, 4'hF);
      check("rst_da", da, 3'b111);
      check("rst_strobes", {nior, niow}, 2'b11);
      check("rst_dtack_oe", {dtack, d_oe, dd_oe, int2}, 4'b0000);
      check("rst_led", led_n, 1'b1);
      n_reset_clocked = 1'b1;
      repeat (2) @(negedge cpuclk7);

      // task-file read: ch1, CS0, da=2
      dd_in = 16'h1234;
      access(24'hDA2008, 1'b1, 16'h0000, 1'b1, 16'h3412, 0);
      check("rd_ack", acked, 1'b1);
      check("rd_setup_len", n_set, SETUP);
      check("rd_nior_len", n_rd, STROBE);
      check("rd_niow_idle", n_wr, 0);
      check("rd_cs_n", cs_seen, 4'b1011);
      check("rd_da", da_seen, 3'd2);
      check("rd_d_oe", d_oe_ack, 1'b1);
      check("rd_end_cs_n", cs_n, 4'hF);
      check("rd_end_da", da, 3'b111);
      check("rd_end_oe", {dtack, d_oe}, 2'b00);

      // task-file write: ch0, CS0, da=1
      access(24'hDA0004, 1'b0, 16'hABCD, 1'b1, 16'hCDAB, 0);
      check("wr_ack", acked, 1'b1);
      check("wr_niow_len", n_wr, STROBE);
      check("wr_nior_idle", n_rd, 0);
      check("wr_cs_n", cs_seen, 4'b1110);
      check("wr_da", da_seen, 3'd1);
      check("wr_dd_oe_span", n_oe, SETUP + STROBE);
      check("wr_dd_oe_ack", dd_oe_ack, 1'b1);
      check("wr_d_oe_ack", d_oe_ack, 1'b0);
      check("wr_end_dd_oe", dd_oe, 1'b0);

      // interrupts
      access(24'hDA9000, 1'b0, 16'h0100, 1'b0, 16'h0, 0);
      check("en_ack", acked, 1'b1);
      pulse_irq0();
      wait_int("int_set", 1'b1);
      access(24'hDA8000, 1'b1, 16'h0, 1'b1, 16'h0100, 0);
      access(24'hDA8000, 1'b0, 16'h0100, 1'b0, 16'h0, 0);
      wait_int("int_clear", 1'b0);
      access(24'hDA8000, 1'b1, 16'h0, 1'b1, 16'h0000, 0);
      pulse_irq0();
      wait_int("int_set2", 1'b1);
      repeat (4) @(negedge cpuclk7);
      // new INTRQ edge lands on the same clock as the clearing write
      access(24'hDA8000, 1'b0, 16'h0100, 1'b0, 16'h0, 1);
      access(24'hDA8000, 1'b1, 16'h0, 1'b1, 16'h0100, 0);
      check("int_set_wins", int2, 1'b1);
      access(24'hDA8000, 1'b0, 16'h0100, 1'b0, 16'h0, 0);
      wait_int("int_clear2", 1'b0);

      // force on channel 1
      access(24'hDA9000, 1'b0, 16'h0200, 1'b0, 16'h0, 0);
      access(24'hDAA000, 1'b0, 16'h0200, 1'b0, 16'h0, 0);
      wait_int("int_force", 1'b1);
      access(24'hDAA000, 1'b1, 16'h0, 1'b1, 16'h0200, 0);
      access(24'hDA8000, 1'b1, 16'h0, 1'b1, 16'h0200, 0);
      access(24'hDA9000, 1'b1, 16'h0, 1'b1, 16'h0200, 0);
      access(24'hDAB000, 1'b1, 16'h0, 1'b1, 16'h2200, 0);

      // unmapped channel 3
      access(24'hDA6000, 1'b1, 16'h0, 1'b0, 16'h0, 0);
      check("unmap_ack", acked, 1'b0);
      check("unmap_strobe", n_rd + n_wr, 0);
      check("unmap_cs", n_set, 0);

      // abort during STROBE
      @(negedge cpuclk7);
      AH = 12'hDA2; AL = 3'd0; r_w = 1'b1; nas = 1'b0;
      for (int k = 0; k < 20 && nior; k++) @(negedge cpuclk7);
      check("abort_strobe_seen", nior, 1'b0);
      nas = 1'b1;
      n = 0; saw_ack = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge cpuclk7);
         if (dtack) saw_ack = 1;
         if (!nior) n++;
      end
      check("abort_nior_release", n <= 2, 1'b1);
      check("abort_no_dtack", saw_ack, 1'b0);
      check("abort_idle", {cs_n, nior, d_oe}, {4'hF, 1'b1, 1'b0});

      // LED stretcher
      for (int k = 0; k < 60 && !led_n; k++) @(negedge cpuclk7);
      check("led_idle", led_n, 1'b1);
      ndasp[0] = 1'b0;
      @(negedge cpuclk7);
      ndasp[0] = 1'b1;
      for (int k = 0; k < 10 && led_n; k++) @(negedge cpuclk7);
      check("led_on", led_n, 1'b0);
      n = 0;
      for (int k = 0; k < 40 && !led_n; k++) begin
         n++;
         @(negedge cpuclk7);
      end
      check("led_len", n >= HOLD && n <= HOLD + 1, 1'b1);

      // asynchronous reset mid-STROBE
      @(negedge cpuclk7);
      AH = 12'hDA0; AL = 3'd3; r_w = 1'b0; d_in = 16'h5555; nas = 1'b0;
      for (int k = 0; k < 20 && niow; k++) @(negedge cpuclk7);
      check("rst_mid_strobe_seen", niow, 1'b0);
      #2 n_reset_clocked = 1'b0;
      #1;
      check("arst_cs_da", {cs_n, da}, {4'hF, 3'b111});
      check("arst_strobes", {nior, niow}, 2'b11);
      check("arst_outs", {dtack, d_oe, dd_oe, int2, led_n}, 5'b00001);
      nas = 1'b1;
      repeat (2) @(negedge cpuclk7);
      n_reset_clocked = 1'b1;
      repeat (2) @(negedge cpuclk7);

      check("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ide_multi_port_ctrl.md
Name: ide_multi_port_ctrl

Overview:
Parametrised successor to the single-port A500 IDE glue. Serves NCH IDE ports behind one Zorro-less 68000 I/O window. Generates PIO strobes with programmable setup/strobe timing, so strobe timing no longer follows raw nas. Adds per-channel interrupt pending/enable/force registers and an activity-LED stretcher. Sits between the CPU bus pins and the IDE connector(s); the top level supplies the tristate and open-drain wrappers.

Parameters:
NCH, 2, number of IDE ports (1..4)
BASE, 8'hDA, AH[23:16] value of the I/O window
SETUP_CYC, 1, cpuclk7 cycles from decode to strobe assertion (1..7)
STROBE_CYC, 3, cpuclk7 cycles nior/niow held low (1..15)
LED_HOLD, 16, cpuclk7 cycles led_n held low after last activity (1..255)

Ports:
cpuclk7  in  1  7 MHz CPU clock
n_reset_clocked  in  1  reset, asynchronous, active-low
nas  in  1  68000 address strobe, active-low, asynchronous to clock
r_w  in  1  1=read
AH  in  12  CPU address [23:12]
AL  in  3  CPU address [4:2], task-file register select
d_in  in  16  CPU data bus input
d_out  out  16  CPU data to drive
d_oe  out  1  enable for d_out
dd_in  in  16  IDE data bus input
dd_out  out  16  IDE data to drive
dd_oe  out  1  enable for dd_out
ide_intrq  in  NCH  per-channel INTRQ, active-high
ndasp  in  NCH  per-channel DASP, active-low
cs_n  out  2*NCH  {CS1,CS0} per channel, active-low
da  out  3  IDE register address
nior  out  1  IDE read strobe, active-low
niow  out  1  IDE write strobe, active-low
dtack  out  1  active-high; top level drives open-drain ndtack
int2  out  1  active-high interrupt request
led_n  out  1  activity LED, active-low

Behaviour:
- Reset values: cs_n all 1, da=3'b111, nior=niow=1, dtack=0, d_oe=dd_oe=0, int2=0, led_n=1, pending=enable=force=0, FSM=IDLE.
- nas goes through a 2-flop synchroniser (as_s = !nas synchronised). Decode uses AH/AL/r_w directly, sampled on the clock where FSM leaves IDLE.
- Decode, with AH[23:16]==BASE:
  - AH[15]=0: task file. Channel = AH[14:13]; AH[12] selects CS1 (1) or CS0 (0). A channel >= NCH is unmapped.
  - AH[15]=1: register. AH[13:12]: 0=PENDING, 1=ENABLE, 2=FORCE, 3=ID.
- Unmapped addresses: FSM stays IDLE, no dtack, no drive.
- FSM states: IDLE, SETUP, STROBE, REG, ACK.
  - IDLE -> SETUP on as_s with a task-file hit. Latch channel, cs, da<=AL, r_w. cs_n of the selected channel goes low.
  - IDLE -> REG on as_s with a register hit.
  - SETUP: count SETUP_CYC clocks, then go to STROBE.
  - STROBE: nior (read) or niow (write) low for exactly STROBE_CYC clocks.
    - Write: dd_oe=1 from SETUP entry to ACK exit.
    - Read: on the last STROBE clock, latch d_out <= {dd_in[7:0],dd_in[15:8]}. Then go to ACK.
  - REG: one clock, performs the register read/write, then goes to ACK.
  - ACK: dtack=1. On a read, d_oe=1. Stay until as_s=0, then go to IDLE; cs_n->1 and da->3'b111 on the same edge.
- dd_out = {d_in[7:0],d_in[15:8]} (byte swap, fixed).
- Abort: as_s falling in any non-IDLE state sends the FSM to IDLE next clock. All strobes, dtack and oe deassert; no register write occurs if REG was not reached.
- Registers use D[8+i] for channel i; unused bits read 0.
  - PENDING read: pending bits. Write: 1 clears a bit, 0 leaves it unchanged.
  - ENABLE and FORCE: read/write.
  - ID read: D[15:12]=NCH, D[11:8]=4'h2.
- Interrupts: src[i] = 2-flop-synchronised ide_intrq[i] | force[i]. A rising edge of src[i] sets pending[i]. If set and clear land on the same clock, set wins. int2 = |(pending & enable), registered (1-clock latency).
- LED: 8-bit down-counter. Reloaded to LED_HOLD on any synchronised ndasp low or any STROBE-state clock; otherwise decrements, saturating at 0. led_n = (count==0).
- Reset mid-operation returns everything to reset values asynchronously.

Test Plan:
- Defaults SETUP_CYC=1, STROBE_CYC=3: read at 0xDA2008 (ch1, CS0, da=2), dd_in=16'h1234 -> cs_n[2]=0; nior low exactly 3 clocks after 1 setup clock; d_out=16'h3412; dtack until nas high; then cs_n all 1, da=7.
- Write 16'hABCD to 0xDA0004 -> niow low 3 clocks; dd_out=16'hCDAB; dd_oe spans SETUP..ACK.
- ENABLE=1 (write D[8]=1 to 0xDA9000), pulse ide_intrq[0] -> pending=1 and int2=1 within 4 clocks. Write 1 to PENDING -> int2=0. Repeat with the clear write on the same clock as a new edge -> pending stays 1.
- FORCE[1]=1 with enable[1]=1 -> int2=1. Read ID at 0xDAB000 -> D[15:8]=8'h22.
- nas deasserts during STROBE -> nior=1 next clock, no dtack, FSM IDLE. Access to channel 3 with NCH=2 -> no dtack, no strobe.
- ndasp[0] low 1 clock -> led_n low for LED_HOLD+1 clocks, then 1. Assert n_reset_clocked low mid-STROBE -> all outputs at reset values immediately.
